// File: rtl/fft_write_ram_if.sv
// Sample stream in, SRAM write port and frame status out of fft_write_ram.
// slave modport is the writer; master is the producer/controller side.
interface fft_write_ram_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int SWIDTH = 16
);
   logic              start_in;
   logic              s_valid_in;
   logic              s_ready_out;
   logic [SWIDTH-1:0] s_re_in;
   logic [SWIDTH-1:0] s_im_in;
   logic              s_last_in;
   logic              mem_en_out;
   logic              mem_we_out;
   logic [AWIDTH-1:0] mem_addr_out;
   logic [DWIDTH-1:0] mem_d_out;
   logic              busy_out;
   logic              done_out;
   logic              err_out;

   modport slave (
      input  start_in, s_valid_in, s_re_in, s_im_in, s_last_in,
      output s_ready_out, mem_en_out, mem_we_out, mem_addr_out, mem_d_out,
             busy_out, done_out, err_out
   );

   modport master (
      output start_in, s_valid_in, s_re_in, s_im_in, s_last_in,
      input  s_ready_out, mem_en_out, mem_we_out, mem_addr_out, mem_d_out,
             busy_out, done_out, err_out
   );
endinterface

// File: rtl/fft_write_ram.sv
// Packs one FFT frame of {im,re} samples into dual_sram writes; BITREV_ADDR_EN loads in bit-reversed order.
// Write strobe 1 cycle after accept; ready only while a frame is open, dropped after the final accept.
module fft_write_ram #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int SWIDTH = 16
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   fft_write_ram_if.slave s
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t            state;
   logic [AWIDTH-1:0] count;
   logic              ready_q;
   logic              en_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] d_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic accept;
   logic full;
   logic frame_end;

   function automatic logic [AWIDTH-1:0] wr_addr(input logic [AWIDTH-1:0] c);
      logic [AWIDTH-1:0] r;
`ifdef BITREV_ADDR_EN
      for (int i = 0; i < AWIDTH; i++) r[i] = c[AWIDTH-1-i];
`else
      r = c;
`endif
      return r;
   endfunction

   assign accept    = s.s_valid_in & ready_q;
   assign full      = &count;
   assign frame_end = accept & (s.s_last_in | full);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state   <= IDLE;
         count   <= '0;
         ready_q <= 1'b0;
         en_q    <= 1'b0;
         addr_q  <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         en_q   <= accept;
         done_q <= 1'b0;
         if (accept) begin
            addr_q <= wr_addr(count);
            d_q    <= {s.s_im_in, s.s_re_in};
         end
         case (state)
            IDLE: begin
               if (s.start_in) begin
                  state   <= WRITE;
                  count   <= '0;
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            WRITE: begin
               if (accept) count <= count + 1'b1;
               if (frame_end) begin
                  state   <= DONE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // early last, or a full frame without last, are both framing errors
                  if (s.s_last_in != full) err_q <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Holding reset during the strobe cycle keeps the pending beat out of the RAM.
   assign s.mem_en_out   = en_q & rst_n_in;
   assign s.mem_we_out   = en_q & rst_n_in;
   assign s.mem_addr_out = addr_q;
   assign s.mem_d_out    = d_q;
   assign s.s_ready_out  = ready_q;
   assign s.busy_out     = busy_q;
   assign s.done_out     = done_q;
   assign s.err_out      = err_q;
endmodule

// File: tb/tb_fft_write_ram.sv
// Directed bench for fft_write_ram: full, gapped, early-last, missing-last and mid-frame reset frames.
module tb_fft_write_ram;
   localparam int N = 32;

   logic clk_in = 1'b0;
   logic rst_n_in;
   always #5 clk_in = ~clk_in;

   fft_write_ram_if #(.DWIDTH(32), .AWIDTH(5), .SWIDTH(16)) ifc ();

   fft_write_ram dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .s        (ifc.slave)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_addr(input int k);
      logic [4:0] a;
      a = 5'(k);
`ifdef BITREV_ADDR_EN
      return {a[0], a[1], a[2], a[3], a[4]};
`else
      return a;
`endif
   endfunction

   // Every strobe must match the next expected write; no strobe means no done either.
   always @(negedge clk_in) begin
      if (ifc.mem_en_out) begin
         if (exp_q.size() == 0) begin
            check("extra_write", ifc.mem_en_out, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("we", ifc.mem_we_out, 1);
            check("addr", ifc.mem_addr_out, e.addr);
            check("data", ifc.mem_d_out, e.data);
            check("done_with_last", ifc.done_out, e.last);
         end
      end else begin
         check("we_idle", ifc.mem_we_out, 0);
         check("done_alone", ifc.done_out, 0);
      end
   end

   task automatic push_beats(input int first, input int last_k, input int end_beat);
      for (int j = first; j <= last_k; j++)
         exp_q.push_back('{exp_addr(j), {16'(2*j+1), 16'(2*j)}, j == end_beat});
   endtask

   task automatic run_frame(input int last_at, input bit gaps, input bit exp_err, input bit start_in_done);
      int  end_beat;
      int  k;
      int  cyc;
      bit  prev;
      end_beat = (last_at >= 0 && last_at < N-1) ? last_at : N-1;
      push_beats(0, end_beat, end_beat);
      ifc.start_in = 1'b1;
      @(posedge clk_in); #1;
      ifc.start_in = 1'b0;
      k = 0; cyc = 0; prev = 1'b0;
      while (k <= end_beat) begin
         ifc.s_valid_in = !gaps || (cyc % 3 == 0);
         ifc.s_re_in    = 16'(2*k);
         ifc.s_im_in    = 16'(2*k+1);
         ifc.s_last_in  = (k == last_at);
         ifc.start_in   = gaps && (cyc == 4);
         @(negedge clk_in);
         check("ready_in_frame", ifc.s_ready_out, 1);
         check("busy_in_frame", ifc.busy_out, 1);
         check("err_in_frame", ifc.err_out, 0);
         check("strobe_timing", ifc.mem_en_out, prev);
         @(posedge clk_in); #1;
         prev = ifc.s_valid_in;
         if (ifc.s_valid_in) k++;
         cyc++;
      end
      ifc.s_valid_in = 1'b0;
      ifc.s_last_in  = 1'b0;
      ifc.start_in   = start_in_done;
      @(negedge clk_in);
      check("done_pulse", ifc.done_out, 1);
      check("ready_done", ifc.s_ready_out, 0);
      check("busy_done", ifc.busy_out, 0);
      check("err_done", ifc.err_out, exp_err);
      @(posedge clk_in); #1;
      ifc.start_in = 1'b0;
      @(negedge clk_in);
      check("done_once", ifc.done_out, 0);
      check("ready_idle", ifc.s_ready_out, 0);
      check("err_sticky", ifc.err_out, exp_err);
      @(posedge clk_in); #1;
      @(negedge clk_in);
      check("start_in_done_ignored", ifc.s_ready_out, 0);
      check("pending_writes", 32'(exp_q.size()), 0);
      @(posedge clk_in); #1;
   endtask

   initial begin
      rst_n_in       = 1'b0;
      ifc.start_in   = 1'b0;
      ifc.s_valid_in = 1'b0;
      ifc.s_re_in    = '0;
      ifc.s_im_in    = '0;
      ifc.s_last_in  = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_ready", ifc.s_ready_out, 0);
      check("rst_en", ifc.mem_en_out, 0);
      check("rst_addr", ifc.mem_addr_out, 0);
      check("rst_data", ifc.mem_d_out, 0);
      check("rst_busy", ifc.busy_out, 0);
      check("rst_err", ifc.err_out, 0);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("idle_ready", ifc.s_ready_out, 0);
      @(posedge clk_in); #1;

      run_frame(31, 1'b0, 1'b0, 1'b1);   // natural full frame, start pulsed in DONE
      run_frame(31, 1'b1, 1'b0, 1'b0);   // 1,0,0 valid pattern, start pulsed mid-frame
      run_frame(9,  1'b0, 1'b1, 1'b0);   // early last
      run_frame(-1, 1'b0, 1'b1, 1'b0);   // missing last

      // reset in the strobe cycle of beat 5
      push_beats(0, 4, -1);
      ifc.start_in = 1'b1;
      @(posedge clk_in); #1;
      ifc.start_in = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         ifc.s_valid_in = 1'b1;
         ifc.s_re_in    = 16'(2*k);
         ifc.s_im_in    = 16'(2*k+1);
         @(posedge clk_in); #1;
      end
      rst_n_in       = 1'b0;
      ifc.s_valid_in = 1'b0;
      @(negedge clk_in);
      check("rst_drops_beat5", ifc.mem_en_out, 0);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("post_rst_en", ifc.mem_en_out, 0);
      check("post_rst_we", ifc.mem_we_out, 0);
      check("post_rst_addr", ifc.mem_addr_out, 0);
      check("post_rst_data", ifc.mem_d_out, 0);
      check("post_rst_ready", ifc.s_ready_out, 0);
      check("post_rst_busy", ifc.busy_out, 0);
      check("post_rst_done", ifc.done_out, 0);
      check("post_rst_err", ifc.err_out, 0);
      check("rst_pending", 32'(exp_q.size()), 0);
      @(posedge clk_in); #1;

      run_frame(31, 1'b0, 1'b0, 1'b0);   // restart from address 0

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
